// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 arbitrated output-register mux.
//   mux_mode_e : grant policy (MODE_FIXED = external select, MODE_RR = round-robin)
//   sel_width  : width of a channel index for a given channel count, never below 1
package mux_pkg;

    typedef enum logic [0:0] {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    // A single channel still needs one bit of index so ports never collapse to zero width.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_mux_n_to_1_rr_pick.sv
// Rotating priority search used by the round-robin grant.
// Ports:
//   req   [NCH] : request vector
//   ptr   [SW]  : channel that has highest priority this cycle (always < NCH)
//   idx   [SW]  : first requesting channel at or after ptr, wrapping modulo NCH
//   found       : at least one request is present
module rr_pick #(
    parameter int NCH = 4,
    parameter int SW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  ptr,
    output logic [SW-1:0]  idx,
    output logic           found
);

    // Walk offsets 0..NCH-1 from ptr; the wrap subtracts NCH so indices >= NCH never appear.
    always_comb begin : pick_search
        int cand;
        cand  = 0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < NCH; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end else begin
                cand = cand;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = SW'(cand);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/arb_mux_n_to_1.sv
// N-to-1 arbitrated mux with a single registered output stage.
// A channel word is captured into the output register on the edge where it is
// granted; the register accepts a new word whenever it is empty or draining.
// Ports:
//   i_Clk, i_Reset : clock, asynchronous active-high reset
//   i_Valid/i_Data : per-channel request and data (channel k at [k*IW +: IW])
//   o_Ready        : one-hot (or zero) accept back to the granted channel
//   i_Select       : channel choice in MODE_FIXED, ignored in MODE_RR
//   o_Valid/o_Data/o_Channel : registered output word and its source channel
//   i_Ready        : downstream accept
module arb_mux_n_to_1
    import mux_pkg::*;
#(
    parameter int        IW   = 8,
    parameter int        NCH  = 4,
    parameter mux_mode_e MODE = MODE_RR,
    localparam int       SW   = sel_width(NCH)
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NCH-1:0]    i_Valid,
    input  logic [NCH*IW-1:0] i_Data,
    output logic [NCH-1:0]    o_Ready,
    input  logic [SW-1:0]     i_Select,
    output logic              o_Valid,
    output logic [IW-1:0]     o_Data,
    output logic [SW-1:0]     o_Channel,
    input  logic              i_Ready
);

    logic          valid_q, valid_d;
    logic [IW-1:0] data_q, data_d;
    logic [SW-1:0] chan_q, chan_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load_s;
    logic          rr_found_s;
    logic [SW-1:0] rr_idx_s;
    logic          fixed_found_s;
    logic [SW-1:0] g_s;
    logic          grant_s;
    logic [IW-1:0] sel_word_s;

    rr_pick #(
        .NCH (NCH),
        .SW  (SW)
    ) u_rr_pick (
        .req   (i_Valid),
        .ptr   (ptr_q),
        .idx   (rr_idx_s),
        .found (rr_found_s)
    );

    // Grant decision, accept vector and next-state of the output register.
    always_comb begin
        load_s        = !valid_q || i_Ready;
        fixed_found_s = 1'b0;
        // An i_Select value with no matching channel leaves fixed_found_s low.
        for (int k = 0; k < NCH; k++) begin
            if ((i_Select == SW'(k)) && i_Valid[k]) begin
                fixed_found_s = 1'b1;
            end else begin
                fixed_found_s = fixed_found_s;
            end
        end

        if (MODE == MODE_RR) begin
            g_s     = rr_idx_s;
            grant_s = rr_found_s && load_s && !i_Reset;
        end else begin
            g_s     = i_Select;
            grant_s = fixed_found_s && load_s && !i_Reset;
        end

        sel_word_s = '0;
        o_Ready    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (g_s == SW'(k)) begin
                sel_word_s = i_Data[k*IW +: IW];
                o_Ready[k] = grant_s;
            end else begin
                o_Ready[k] = 1'b0;
            end
        end

        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (grant_s) begin
            valid_d = 1'b1;
            data_d  = sel_word_s;
            chan_d  = g_s;
            // Pointer moves past the winner only on an actual transfer.
            if (MODE == MODE_RR) begin
                if (g_s == SW'(NCH-1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = g_s + SW'(1);
                end
            end else begin
                ptr_d = ptr_q;
            end
        end else if (load_s) begin
            // Drained with nothing to refill: word is consumed, data/channel keep last value.
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_Valid   = valid_q;
    assign o_Data    = data_q;
    assign o_Channel = chan_q;

endmodule

// File: tb/tb_arb_mux_n_to_1.sv
// Bench for arb_mux_n_to_1: three instances (4-channel round-robin, 4-channel
// fixed-select, 3-channel round-robin) share one clock and reset. A reference
// model per instance is checked every falling edge, and directed steps pin the
// model with hand-computed literals.
module tb_arb_mux_n_to_1;
    import mux_pkg::*;

    logic        clk;
    logic        rst;

    logic [3:0]  rr_valid, rr_ready_o;
    logic [31:0] rr_data;
    logic [1:0]  rr_sel, rr_chan;
    logic        rr_ovalid, rr_rdy;
    logic [7:0]  rr_odata;

    logic [3:0]  fx_valid, fx_ready_o;
    logic [31:0] fx_data;
    logic [1:0]  fx_sel, fx_chan;
    logic        fx_ovalid, fx_rdy;
    logic [7:0]  fx_odata;

    logic [2:0]  r3_valid, r3_ready_o;
    logic [23:0] r3_data;
    logic [1:0]  r3_sel, r3_chan;
    logic        r3_ovalid, r3_rdy;
    logic [7:0]  r3_odata;

    int n_cmp = 0;
    int n_bad = 0;

    // model state per instance: 0 = rr4, 1 = fixed4, 2 = rr3
    int m_valid [3];
    int m_data  [3];
    int m_chan  [3];
    int m_ptr   [3];

    arb_mux_n_to_1 #(.IW(8), .NCH(4), .MODE(MODE_RR)) dut_rr (
        .i_Clk(clk), .i_Reset(rst), .i_Valid(rr_valid), .i_Data(rr_data),
        .o_Ready(rr_ready_o), .i_Select(rr_sel), .o_Valid(rr_ovalid),
        .o_Data(rr_odata), .o_Channel(rr_chan), .i_Ready(rr_rdy));

    arb_mux_n_to_1 #(.IW(8), .NCH(4), .MODE(MODE_FIXED)) dut_fx (
        .i_Clk(clk), .i_Reset(rst), .i_Valid(fx_valid), .i_Data(fx_data),
        .o_Ready(fx_ready_o), .i_Select(fx_sel), .o_Valid(fx_ovalid),
        .o_Data(fx_odata), .o_Channel(fx_chan), .i_Ready(fx_rdy));

    arb_mux_n_to_1 #(.IW(8), .NCH(3), .MODE(MODE_RR)) dut_r3 (
        .i_Clk(clk), .i_Reset(rst), .i_Valid(r3_valid), .i_Data(r3_data),
        .o_Ready(r3_ready_o), .i_Select(r3_sel), .o_Valid(r3_ovalid),
        .o_Data(r3_odata), .o_Channel(r3_chan), .i_Ready(r3_rdy));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which channel the rules award, or -1 for none.
    function automatic int model_pick(input int mode, input int nch, input logic [15:0] v,
                                      input int sel, input int ptr);
        if (mode == 0) begin
            if (sel < nch && v[sel]) return sel;
            return -1;
        end
        for (int off = 0; off < nch; off++) begin
            if (v[(ptr + off) % nch]) return (ptr + off) % nch;
        end
        return -1;
    endfunction

    // Compare one instance against its model, then advance the model across the next edge.
    task automatic step(input int id, input int mode, input int nch, input logic [15:0] v,
                        input int sel, input logic rdy, input logic [127:0] d,
                        input logic [15:0] a_ready, input logic a_valid,
                        input logic [7:0] a_data, input int a_chan);
        int g;
        int load;
        int exp_ready;
        string tag;
        tag = $sformatf("dut%0d", id);
        if (rst) begin
            m_valid[id] = 0; m_data[id] = 0; m_chan[id] = 0; m_ptr[id] = 0;
        end
        chk({tag, ".o_Valid"},   int'(a_valid), m_valid[id]);
        chk({tag, ".o_Data"},    int'(a_data),  m_data[id]);
        chk({tag, ".o_Channel"}, a_chan,        m_chan[id]);
        load = (m_valid[id] == 0 || rdy) ? 1 : 0;
        g = model_pick(mode, nch, v, sel, m_ptr[id]);
        exp_ready = (!rst && load == 1 && g >= 0) ? (1 << g) : 0;
        chk({tag, ".o_Ready"}, int'(a_ready), exp_ready);
        if (!rst) begin
            if (load == 1 && g >= 0) begin
                m_valid[id] = 1;
                m_data[id]  = int'(d[g*8 +: 8]);
                m_chan[id]  = g;
                if (mode == 1) m_ptr[id] = (g + 1) % nch;
            end else if (load == 1) begin
                m_valid[id] = 0;
            end
        end
    endtask

    // Single compare process: every falling edge, all three instances.
    always @(negedge clk) begin
        step(0, 1, 4, {12'd0, rr_valid}, int'(rr_sel), rr_rdy, {96'd0, rr_data},
             {12'd0, rr_ready_o}, rr_ovalid, rr_odata, int'(rr_chan));
        step(1, 0, 4, {12'd0, fx_valid}, int'(fx_sel), fx_rdy, {96'd0, fx_data},
             {12'd0, fx_ready_o}, fx_ovalid, fx_odata, int'(fx_chan));
        step(2, 1, 3, {13'd0, r3_valid}, int'(r3_sel), r3_rdy, {104'd0, r3_data},
             {13'd0, r3_ready_o}, r3_ovalid, r3_odata, int'(r3_chan));
    end

    initial begin
        logic [7:0] seq_a [5];
        int         seq_c [5];
        seq_a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        seq_c = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        rr_valid = 4'b1111; rr_data = 32'hA3A2A1A0; rr_sel = 2'd0; rr_rdy = 1'b1;
        fx_valid = 4'b0000; fx_data = 32'h0;        fx_sel = 2'd2; fx_rdy = 1'b1;
        r3_valid = 3'b111;  r3_data = 24'hB2B1B0;   r3_sel = 2'd0; r3_rdy = 1'b1;

        @(negedge clk);
        chk("reset.rr_ready", int'(rr_ready_o), 0);
        chk("reset.rr_valid", int'(rr_ovalid), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);

        // full round-robin sweep on 4 and 3 channels
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr4.seq_data", int'(rr_odata), int'(seq_a[i]));
            chk("rr4.seq_chan", int'(rr_chan), seq_c[i]);
            if (i < 4) chk("rr3.seq_chan", int'(r3_chan), i % 3);
        end

        // ptr now 1; this edge grants ch1 -> ptr 2, then only ch3/ch1 request
        @(posedge clk); #1;
        rr_valid = 4'b1010; rr_data = 32'hD3C2D1C0; r3_valid = 3'b000;
        @(negedge clk);
        chk("rr4.wrap_ready0", int'(rr_ready_o), 4'b1000);
        @(negedge clk);
        chk("rr4.wrap_chan0", int'(rr_chan), 3);
        chk("rr4.wrap_ready1", int'(rr_ready_o), 4'b0010);
        @(negedge clk);
        chk("rr4.wrap_chan1", int'(rr_chan), 1);
        chk("rr4.wrap_data1", int'(rr_odata), 8'hD1);

        // stall holding 5C, then refill with no bubble
        @(posedge clk); #1;
        rr_valid = 4'b0100; rr_data = 32'h005C0000;
        @(posedge clk); #1;
        rr_rdy = 1'b0; rr_data = 32'h00770000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall.data", int'(rr_odata), 8'h5C);
            chk("stall.ready", int'(rr_ready_o), 0);
        end
        @(posedge clk); #1 rr_rdy = 1'b1;
        @(negedge clk);
        chk("stall.release_ready", int'(rr_ready_o), 4'b0100);
        @(negedge clk);
        chk("stall.refill_data", int'(rr_odata), 8'h77);
        chk("stall.refill_valid", int'(rr_ovalid), 1);

        // asynchronous reset while stalled
        @(posedge clk); #1 rr_rdy = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("areset.valid", int'(rr_ovalid), 0);
        chk("areset.data", int'(rr_odata), 0);
        chk("areset.chan", int'(rr_chan), 0);
        chk("areset.ready", int'(rr_ready_o), 0);
        rr_valid = 4'b1111; rr_data = 32'hA3A2A1A0;
        @(posedge clk); #1 rst = 1'b0; rr_rdy = 1'b1;
        @(negedge clk);
        chk("areset.first_ready", int'(rr_ready_o), 4'b0001);
        @(negedge clk);
        chk("areset.first_chan", int'(rr_chan), 0);
        chk("areset.first_data", int'(rr_odata), 8'hA0);

        // fixed select: fill, miss on select, then hit on ch2
        @(posedge clk); #1;
        rr_valid = 4'b0000; fx_valid = 4'b0100; fx_data = 32'h00110000;
        @(posedge clk); #1 fx_valid = 4'b0001;
        @(negedge clk);
        chk("fixed.fill_data", int'(fx_odata), 8'h11);
        chk("fixed.miss_ready", int'(fx_ready_o), 0);
        @(posedge clk); #1;
        fx_valid = 4'b0100; fx_data = 32'h003F0000;
        @(negedge clk);
        chk("fixed.fall_valid", int'(fx_ovalid), 0);
        chk("fixed.hold_data", int'(fx_odata), 8'h11);
        @(posedge clk); #1 fx_valid = 4'b0000;
        @(negedge clk);
        chk("fixed.hit_data", int'(fx_odata), 8'h3F);
        chk("fixed.hit_chan", int'(fx_chan), 2);
        chk("fixed.hit_valid", int'(fx_ovalid), 1);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arb_mux_n_to_1.md
ARB_MUX_N_TO_1 -- requirements
Module: arb_mux_n_to_1

Interface
REQ-001 SHALL have parameter IW, default 8, data width per channel.
REQ-002 SHALL have parameter NCH, default 4, input channel count (legal 2..16).
REQ-003 SHALL have parameter MODE, default MODE_RR, grant mode: MODE_FIXED (external select) or MODE_RR (round-robin).
REQ-004 SHALL define SW = max(1, clog2(NCH)) as a derived localparam, not overridable.
REQ-005 SHALL have port i_Clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_Reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port i_Valid  input  NCH  per-channel data valid.
REQ-008 SHALL have port i_Data  input  NCH*IW  channel k in bits [k*IW +: IW].
REQ-009 SHALL have port o_Ready  output  NCH  per-channel accept, one-hot or zero.
REQ-010 SHALL have port i_Select  input  SW  channel choice, used only in MODE_FIXED.
REQ-011 SHALL have port o_Valid  output  1  output register holds a word.
REQ-012 SHALL have port o_Data  output  IW  registered selected word.
REQ-013 SHALL have port o_Channel  output  SW  source channel index of o_Data.
REQ-014 SHALL have port i_Ready  input  1  downstream accept.

Function
REQ-015 Load enable SHALL be load = !o_Valid || i_Ready (one output register; accepts while draining).
REQ-016 MODE_FIXED: granted channel g = i_Select; grant valid iff i_Valid[g] && load; i_Select >= NCH SHALL grant nothing.
REQ-017 MODE_RR: g = first k with i_Valid[k] set, searching ptr, ptr+1, ..., wrapping modulo NCH (not modulo 2^SW).
REQ-018 o_Ready[g] SHALL be 1 only when grant valid; all other o_Ready bits 0; o_Ready is combinational from i_Valid, i_Select, i_Ready, state.
REQ-019 A transfer on channel k occurs when i_Valid[k] && o_Ready[k]; on that edge o_Data<=word k, o_Channel<=k, o_Valid<=1.
REQ-020 Latency SHALL be exactly 1 cycle from input transfer to o_Valid.
REQ-021 When load && no grant, o_Valid SHALL go to 0 at the edge; o_Data/o_Channel keep their last value.
REQ-022 While o_Valid && !i_Ready, o_Data, o_Channel, o_Valid SHALL be held stable and all o_Ready 0.
REQ-023 Simultaneous drain and refill (o_Valid && i_Ready && grant) SHALL sustain one word per cycle with no bubble.
REQ-024 MODE_RR: ptr SHALL update to (g+1) mod NCH only on a transfer; unchanged otherwise (no advance on stall or idle).
REQ-025 MODE_RR fairness: with all channels continuously valid and i_Ready=1, each channel SHALL be granted once per NCH cycles.
REQ-026 MODE_FIXED: ptr SHALL be unused and held at reset value.
REQ-027 No data combinational path from i_Data to o_Data.

Reset
REQ-028 On i_Reset=1 (any time, asynchronous): o_Valid=0, o_Data=0, o_Channel=0, ptr=0.
REQ-029 Reset mid-stall SHALL discard the held word; no o_Ready asserted while i_Reset=1.
REQ-030 First grant after reset in MODE_RR SHALL prioritise channel 0.

Structure
REQ-031 Shared package mux_pkg SHALL hold typedef enum mux_mode_e {MODE_FIXED, MODE_RR} and clog2-based width helper.
REQ-032 Sub-module rr_pick SHALL implement the combinational rotating priority search (inputs req[NCH], ptr; outputs idx, found).
REQ-033 All sequential state SHALL live in one always_ff with asynchronous reset in arb_mux_n_to_1.

Verification (NCH=4, IW=8)
REQ-034 MODE_RR, reset release, i_Valid=4'b1111, data 8'hA0..8'hA3, i_Ready=1 -> o_Data A0,A1,A2,A3,A0 on consecutive cycles, o_Channel 0,1,2,3,0.
REQ-035 MODE_RR, i_Valid=4'b1010 after ptr=2 -> grants ch3 then ch1 (wrap), o_Ready 4'b1000 then 4'b0010.
REQ-036 Stall: o_Valid=1 holding 8'h5C, i_Ready=0 for 3 cycles -> o_Data stays 8'h5C, o_Ready=0, ptr unchanged; i_Ready=1 with ch2 valid -> next word loaded same edge, no bubble.
REQ-037 MODE_FIXED, i_Select=2, i_Valid=4'b0001 -> no grant, o_Valid falls to 0; then i_Valid=4'b0100, data 8'h3F -> o_Data=8'h3F, o_Channel=2 one cycle later.
REQ-038 Assert i_Reset asynchronously mid-stall with o_Valid=1 -> o_Valid, o_Data, o_Channel 0 immediately; after release, ch0 granted first.
REQ-039 NCH=3 MODE_RR, all valid -> channel sequence 0,1,2,0 (no index 3), confirming modulo-NCH wrap.
